// File: rtl/kme_fifo_pkt_arb.sv
// Packet-granular round-robin arbiter in front of a KME stall-style FIFO write port.
// Optional idle watchdog enabled by defining KME_FIFO_PKT_ARB_WDOG_EN.
module kme_fifo_pkt_arb #(
  parameter int N_REQ       = 4,
  parameter int DATA_SIZE   = 611,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_eop,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic [DATA_SIZE-1:0]       fifo_in,
  output logic                       fifo_in_valid,
  input  logic                       fifo_in_stall,
  input  logic                       fifo_overflow,
  input  logic                       fifo_underflow,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic [1:0]                 err_sticky,
  input  logic                       err_clr,
  output logic                       wdog_timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [1:0]       err_q, err_d;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             any_valid;
  logic             beat;
  logic             release_pkt;

`ifdef KME_FIFO_PKT_ARB_WDOG_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       wto_q, wto_d;
  assign wdog_timeout = wto_q;
`else
  assign wdog_timeout = 1'b0;
`endif

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return IDX_W'(int'(idx) + 1);
  endfunction

  // Round-robin search: lowest offset from rr_ptr wins, so scan offsets downward.
  always_comb begin
    winner    = rr_ptr_q;
    cand      = '0;
    any_valid = |req_valid;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (int'(rr_ptr_q) + k >= N_REQ) cand = IDX_W'(int'(rr_ptr_q) + k - N_REQ);
      else                             cand = IDX_W'(int'(rr_ptr_q) + k);
      if (req_valid[cand]) winner = cand;
    end
  end

  assign beat          = (state_q == BUSY) & req_valid[gidx_q] & ~fifo_in_stall;
  assign fifo_in_valid = beat;
  assign req_ack       = beat ? grant_q : '0;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign err_sticky    = err_q;

  always_comb begin
    fifo_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) fifo_in = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    release_pkt = 1'b0;
    // A pulse arriving together with err_clr must stay visible.
    err_d       = (err_q & ~{2{err_clr}}) | {fifo_underflow, fifo_overflow};
`ifdef KME_FIFO_PKT_ARB_WDOG_EN
    wcnt_d      = wcnt_q;
    wto_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = BUSY;
          gidx_d  = winner;
          grant_d = N_REQ'(1) << winner;
          busy_d  = 1'b1;
`ifdef KME_FIFO_PKT_ARB_WDOG_EN
          wcnt_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (beat && req_eop[gidx_q]) release_pkt = 1'b1;
`ifdef KME_FIFO_PKT_ARB_WDOG_EN
        if (beat) begin
          wcnt_d = '0;
        end else if (!req_valid[gidx_q]) begin
          if (wcnt_q == 8'(WDOG_CYCLES - 1)) begin
            release_pkt = 1'b1;
            wto_d       = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (release_pkt) begin
      state_d  = IDLE;
      grant_d  = '0;
      busy_d   = 1'b0;
      rr_ptr_d = wrap_inc(gidx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 2'b00;
`ifdef KME_FIFO_PKT_ARB_WDOG_EN
      wcnt_q   <= '0;
      wto_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef KME_FIFO_PKT_ARB_WDOG_EN
      wcnt_q   <= wcnt_d;
      wto_q    <= wto_d;
`endif
    end
  end

endmodule

// File: tb/tb_kme_fifo_pkt_arb.sv
// Scoreboard bench for kme_fifo_pkt_arb: randomized requester agents, packet-level reference model.
module tb_kme_fifo_pkt_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WD = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_eop, req_ack, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   fifo_in;
  logic            fifo_in_valid, fifo_in_stall, fifo_overflow, fifo_underflow;
  logic            busy, err_clr, wdog_timeout;
  logic [1:0]      err_sticky;

  kme_fifo_pkt_arb #(.N_REQ(N), .DATA_SIZE(DW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_eop(req_eop),
    .req_data(req_data), .req_ack(req_ack), .fifo_in(fifo_in),
    .fifo_in_valid(fifo_in_valid), .fifo_in_stall(fifo_in_stall),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .grant(grant), .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr),
    .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  ack;
    logic          fv;
    logic [DW-1:0] fd;
    logic [N-1:0]  grant;
    logic          busy;
    logic [1:0]    err;
    logic          wto;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Requester agents
  logic          a_hold [N];
  logic [DW-1:0] a_data [N];
  logic          a_eop  [N];
  int            a_left [N];

  // Reference model: owner -1 means no packet in progress
  int       m_owner, m_ptr, m_idle;
  logic [1:0] m_err;
  logic     m_wto;

  // Stimulus knobs
  logic [N-1:0] act_mask;
  int  vprob, fixlen, stall_mode, err_mode, rst_prob;
  logic stall_f, of_f, uf_f, clr_f;
  bit  chk_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req_ack", 64'(req_ack), 64'(e.ack));
      chk("fifo_in_valid", 64'(fifo_in_valid), 64'(e.fv));
      if (e.fv) chk("fifo_in", 64'(fifo_in), 64'(e.fd));
      chk("grant", 64'(grant), 64'(e.grant));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("err_sticky", 64'(err_sticky), 64'(e.err));
      chk("wdog_timeout", 64'(wdog_timeout), 64'(e.wto));
    end
  end

  task automatic cycle();
    exp_t e;
    bit   beat, rel, found;
    int   idx;
    // agents present new beats when idle
    for (int i = 0; i < N; i++) begin
      if (!a_hold[i] && act_mask[i] && ($urandom_range(0, 99) < vprob)) begin
        if (a_left[i] == 0) a_left[i] = (fixlen > 0) ? fixlen : int'($urandom_range(1, 4));
        a_data[i] = $urandom;
        a_left[i]--;
        a_eop[i]  = (a_left[i] == 0);
        a_hold[i] = 1'b1;
      end
    end
    fifo_in_stall  = (stall_mode < 0) ? ($urandom_range(0, 99) < 30) : stall_f;
    fifo_overflow  = (err_mode < 0) ? ($urandom_range(0, 99) < 3) : of_f;
    fifo_underflow = (err_mode < 0) ? ($urandom_range(0, 99) < 3) : uf_f;
    err_clr        = (err_mode < 0) ? ($urandom_range(0, 99) < 5) : clr_f;
    if (rst_prob > 0 && $urandom_range(0, rst_prob - 1) == 0) rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = a_hold[i];
      req_eop[i]              = a_hold[i] ? a_eop[i] : 1'b0;
      req_data[i*DW +: DW]    = a_data[i];
    end
    // expected response for this cycle
    beat    = (m_owner >= 0) && a_hold[m_owner] && !fifo_in_stall;
    e.grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.busy  = (m_owner >= 0);
    e.ack   = beat ? N'(1) << m_owner : '0;
    e.fv    = beat;
    e.fd    = (m_owner >= 0) ? a_data[m_owner] : '0;
    e.err   = m_err;
    e.wto   = m_wto;
    if (chk_en) exp_q.push_back(e);
    // advance the model across the coming edge
    m_wto = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_err = 2'b00; m_idle = 0;
    end else begin
      m_err = (err_clr ? 2'b00 : m_err) | {fifo_underflow, fifo_overflow};
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && a_hold[idx]) begin
            found = 1; m_owner = idx; m_idle = 0;
          end
        end
      end else begin
        rel = beat && a_eop[m_owner];
`ifdef KME_FIFO_PKT_ARB_WDOG_EN
        if (beat) m_idle = 0;
        else if (!a_hold[m_owner]) begin
          if (m_idle == WD - 1) begin
            rel = 1; m_wto = 1'b1;
          end else m_idle++;
        end
`endif
        if (rel) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (e.ack[i]) a_hold[i] = 1'b0;
      if (!rst_n) begin
        a_hold[i] = 1'b0; a_left[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_hold[i] = 1'b0; a_data[i] = '0; a_eop[i] = 1'b0; a_left[i] = 0;
    end
    m_owner = -1; m_ptr = 0; m_err = 2'b00; m_idle = 0; m_wto = 1'b0;
    act_mask = '0; vprob = 100; fixlen = 0; stall_mode = 0; err_mode = 0;
    rst_prob = 0; stall_f = 0; of_f = 0; uf_f = 0; clr_f = 0; chk_en = 0;
    req_valid = '0; req_eop = '0; req_data = '0; fifo_in_stall = 0;
    fifo_overflow = 0; fifo_underflow = 0; err_clr = 0;

    // reset: first cycle state unknown, second cycle checks reset values
    rst_n = 1'b0;
    #1;
    cycle();
    rst_n = 1'b0;
    chk_en = 1;
    cycle();

    // single requester, 3-beat packets
    act_mask = 4'b0001; fixlen = 3;
    run(4);
    act_mask = '0;
    run(4);

    // full contention with 2-beat packets
    act_mask = 4'b1111; fixlen = 2;
    run(30);
    act_mask = '0;
    run(6);

    // stall held across a packet of req2
    act_mask = 4'b0100; fixlen = 2;
    run(2);
    act_mask = '0;
    stall_f = 1; run(5);
    stall_f = 0; run(4);

    // reset in the middle of a 4-beat packet
    act_mask = 4'b0010; fixlen = 4;
    run(3);
    rst_n = 1'b0;
    cycle();
    act_mask = 4'b1111;
    run(6);
    act_mask = '0;
    run(6);

    // error flags: overflow, clear, then underflow with clear
    of_f = 1; cycle(); of_f = 0;
    cycle();
    clr_f = 1; cycle(); clr_f = 0;
    cycle();
    uf_f = 1; clr_f = 1; cycle(); uf_f = 0; clr_f = 0;
    run(2);

    // randomized traffic with idle gaps long enough to exercise the watchdog
    act_mask = 4'b1111; fixlen = 0; stall_mode = -1; err_mode = -1;
    vprob = 8;
    run(400);
    vprob = 60; rst_prob = 200;
    run(2000);

    chk_en = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kme_fifo_pkt_arb.md
Name: kme_fifo_pkt_arb

Overview:
- Packet-granular round-robin arbiter that shares one KME stall-style FIFO between N_REQ requesters.
- Selects one requester, holds the grant until that requester's end-of-packet beat, then passes ownership on in round-robin order.
- Throttles beats using the FIFO's fifo_in_stall so the FIFO is never written while it has zero free slots.
- Sits directly in front of the KME FIFO write port. Also collects the FIFO's overflow and underflow pulses into sticky error flags.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- DATA_SIZE, 611: beat width in bits, equal to the FIFO data width.
- WDOG_CYCLES, 64: idle-cycle limit for the watchdog (optional feature only), 2..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester beat valid.
- req_eop  in  N_REQ  per-requester last beat of packet, qualified by req_valid.
- req_data  in  N_REQ*DATA_SIZE  requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_ack  out  N_REQ  beat accepted this cycle.
- fifo_in  out  DATA_SIZE  write data to the FIFO.
- fifo_in_valid  out  1  write enable to the FIFO.
- fifo_in_stall  in  1  FIFO has no free slot (or is overridden).
- fifo_overflow  in  1  FIFO overflow pulse.
- fifo_underflow  in  1  FIFO underflow pulse.
- grant  out  N_REQ  one-hot current owner, all zero when idle.
- busy  out  1  a packet is in progress.
- err_sticky  out  2  bit0 = overflow seen, bit1 = underflow seen.
- err_clr  in  1  clears err_sticky.
- wdog_timeout  out  1  watchdog pulse (optional feature only).

Behaviour:
- Reset: while rst_n=0 at a clk edge:
  - state=IDLE, rr_ptr=0, grant=0, busy=0, err_sticky=0, wdog_timeout=0.
  - Combinational outputs then evaluate to req_ack=0 and fifo_in_valid=0.
  - fifo_in is don't-care whenever fifo_in_valid=0.
- IDLE state:
  - If any req_valid is set, the winner is the first set bit searching from index rr_ptr upward, wrapping at N_REQ-1 to 0.
  - On that edge, grant <= onehot(winner), busy <= 1, state <= BUSY.
  - No beat is accepted in IDLE. Arbitration latency is therefore 1 cycle, and the first beat can be accepted the cycle after the request is seen.
  - Arbitration ignores fifo_in_stall.
- BUSY state, with g the granted index:
  - beat = req_valid[g] & ~fifo_in_stall.
  - fifo_in_valid = beat, req_ack[g] = beat, fifo_in = req_data[g]. All three are combinational from the current inputs.
  - req_ack of every other requester is 0.
  - A beat with req_eop[g]=1 ends the packet. On that edge: state <= IDLE, grant <= 0, busy <= 0, rr_ptr <= (g+1) mod N_REQ.
  - A single-beat packet (valid and eop together) is legal.
- Handshake rules:
  - A requester holds valid, data and eop stable until acked.
  - Valid may drop between beats inside a packet; the grant is kept.
  - Other requesters' valids do not affect BUSY.
- Stall: while fifo_in_stall=1, fifo_in_valid=0 and the grant is held indefinitely. This includes an eop beat held under stall, which completes in the first cycle stall is low.
- Fairness: back-to-back packets need one IDLE cycle between them. With all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
- Errors:
  - err_sticky[0] <= 1 on fifo_overflow; err_sticky[1] <= 1 on fifo_underflow.
  - err_clr clears both bits.
  - If err_clr and a pulse arrive in the same cycle, the set wins.
- Reset mid-packet: the packet is abandoned, all state returns to reset values, and no further acks are given to the old owner.

Optional Feature:
- Macro: KME_FIFO_PKT_ARB_WDOG_EN.
- Defined:
  - An 8-bit idle counter resets to 0 on entry to BUSY and on every accepted beat.
  - It increments each BUSY cycle with req_valid[g]=0. Stalled cycles with valid=1 do not count.
  - When the counter reaches WDOG_CYCLES-1 and another idle cycle occurs, the arbiter forces IDLE on that edge: grant <= 0, busy <= 0, rr_ptr <= g+1.
  - wdog_timeout is registered and pulses for 1 cycle, in the cycle after the release edge.
- Undefined: the counter is absent, wdog_timeout is tied to 0, and a BUSY owner is held indefinitely.

Test Plan:
- Single requester, with N_REQ=4: req0 sends a 3-beat packet with stall=0. Required: grant=0001 from cycle 1; acks in cycles 1, 2, 3; busy drops after cycle 3; rr_ptr=1.
- Contention: req0..req3 each continuously send 2-beat packets. Required: grant order 0,1,2,3,0; exactly 1 idle cycle between packets; fifo_in_valid never asserted in IDLE.
- Stall: fifo_in_stall=1 for 5 cycles during the eop beat of req2. Required: no ack and fifo_in_valid=0 for 5 cycles; eop accepted on the 6th cycle; grant then released.
- Reset mid-packet: rst_n=0 for 1 cycle after 2 of 4 beats. Required: grant=0, busy=0, req_ack=0 the next cycle; the next arbitration starts from index 0.
- Errors: fifo_overflow pulse, then err_clr, then fifo_underflow and err_clr in the same cycle. Required sequence: err_sticky=01, then 00, then 10.
- Watchdog, with WDOG defined and WDOG_CYCLES=8: owner drops valid mid-packet. Required: release after 8 idle cycles; a 1-cycle wdog_timeout pulse; the next requester is granted.
